rand_sched: RTL

RAND_SCHED -- requirements
Module: rand_sched

---
 rtl/rand_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rand_sched.sv
//==============================================================================
// Module   : rand_sched
// Purpose  : Shares one external 9-bit LFSR among NREQ requesters. The LFSR
//            is seeded from a free-running counter on the first start pulse.
//            Samples are then handed out round-robin, at least GAP LFSR
//            steps apart, as one-cycle one-hot grants carrying the sample.
// Options  : `define RAND_SCHED_RANGE_CLAMP_EN to reject samples above the
//            selected requester's inclusive limit. A rejected sample does not
//            advance the round-robin pointer, so the requester retries first.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rand_sched #(
  parameter int NREQ = 4,
  parameter int GAP  = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*9-1:0] limit,
  input  logic [8:0]        lfsr_outp,
  output logic [8:0]        lfsr_seed,
  output logic              lfsr_seed_in,
  output logic [NREQ-1:0]   gnt,
  output logic [8:0]        rand_val,
  output logic              ready
);

  localparam int              c_pw      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [c_pw-1:0] c_ptr_rst = c_pw'(NREQ - 1);
  localparam logic [3:0]      c_gap     = 4'(GAP);

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    SEED     = 2'd1,
    WAIT     = 2'd2,
    ARB      = 2'd3
  } state_t;

  state_t          state_q;
  logic [8:0]      ctr_q;
  logic [8:0]      ctr_d;
  logic [8:0]      seed_d;
  logic [3:0]      gap_q;
  logic [c_pw-1:0] ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic [8:0]      rand_val_q;
  logic [8:0]      seed_q;
  logic            seed_in_q;
  logic            ready_q;

  logic [c_pw-1:0] rr_cand;
  logic [c_pw-1:0] rr_idx;
  logic            rr_vld;
  logic [NREQ-1:0] rr_onehot;
  logic            sample_ok;

  assign ctr_d = ctr_q + 9'd1;
  // An all-ones seed would lock up the LFSR, so it is replaced by 1.
  assign seed_d = (ctr_q == 9'h1FF) ? 9'h001 : ctr_q;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    rr_vld  = 1'b0;
    rr_idx  = ptr_q;
    rr_cand = ptr_q;
    for (int i = 1; i <= NREQ; i++) begin
      rr_cand = c_pw'((int'(ptr_q) + i) % NREQ);
      if (!rr_vld && req[rr_cand]) begin
        rr_vld = 1'b1;
        rr_idx = rr_cand;
      end
    end
  end

  assign rr_onehot = NREQ'(1) << rr_idx;

`ifdef RAND_SCHED_RANGE_CLAMP_EN
  logic [8:0] sel_limit;

  // Accept the current sample only if it fits the selected requester's limit.
  always_comb begin
    sel_limit = 9'h1FF;
    for (int k = 0; k < NREQ; k++) begin
      if (rr_idx == c_pw'(k)) begin
        sel_limit = limit[9*k +: 9];
      end
    end
    sample_ok = (lfsr_outp <= sel_limit);
  end
`else
  logic unused_limit;

  assign unused_limit = ^limit;
  assign sample_ok    = 1'b1;
`endif

  // Scheduler state machine; every output is registered here.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= UNSEEDED;
      ctr_q      <= 9'd0;
      gap_q      <= 4'd0;
      ptr_q      <= c_ptr_rst;
      gnt_q      <= '0;
      rand_val_q <= 9'd0;
      seed_q     <= 9'd0;
      seed_in_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      gnt_q     <= '0;
      seed_in_q <= 1'b0;
      case (state_q)
        UNSEEDED: begin
          ready_q <= 1'b0;
          if (start) begin
            seed_q    <= seed_d;
            seed_in_q <= 1'b1;
            state_q   <= SEED;
          end
        end
        SEED: begin
          // The first wait lets the freshly loaded LFSR settle; not ready yet.
          gap_q   <= c_gap;
          ready_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (gap_q <= 4'd1) begin
            gap_q   <= 4'd0;
            ready_q <= 1'b1;
            state_q <= ARB;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        ARB: begin
          if (rr_vld) begin
            if (sample_ok) begin
              gnt_q      <= rr_onehot;
              rand_val_q <= lfsr_outp;
              ptr_q      <= rr_idx;
            end
            // A rejected sample still costs a full gap before the retry.
            gap_q   <= c_gap;
            ready_q <= 1'b1;
            state_q <= WAIT;
          end
        end
        default: begin
          state_q <= UNSEEDED;
        end
      endcase
    end
  end

  assign lfsr_seed    = seed_q;
  assign lfsr_seed_in = seed_in_q;
  assign gnt          = gnt_q;
  assign rand_val     = rand_val_q;
  assign ready        = ready_q;

endmodule

`default_nettype wire
